uart_rx: RTL and testbench

Serial 8N1 UART receiver for the board-level test designs. It oversamples the asynchronous `rx` pin on the fabric clock, recovers start, data and stop bits, and presents each byte as a one-cycle `valid` strobe. It replaces the `rx`→`tx` pin loopback with a decoded byte stream that the top level can route to `led`, or to a UART transmitter for echo.

---
 rtl/uart_rx.sv | 95 +++++++++
 tb/tb_uart_rx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with framing-error and break handling
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int N = CLKS_PER_BIT;
  localparam int H = N / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] HM = CW'(H - 1);
  localparam logic [CW-1:0] NM = CW'(N - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic s1, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  logic valid_n, ferr_n;
  assign busy = state != IDLE;
  // Two-flop synchronizer, then state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1        <= rx;
      rx_s      <= s1;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end
  // Bit timing: start sampled at half period, data and stop at full periods after that
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        cnt_n = cnt + 1'b1;
        if (cnt == HM) begin
          state_n = rx_s ? IDLE : DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (cnt == NM) begin
          sh_n    = {rx_s, sh[7:1]};
          cnt_n   = '0;
          idx_n   = idx + 1'b1;
          state_n = idx == 3'd7 ? STOP : DATA;
        end
      end
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == NM) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : BRK;
          data_n  = rx_s ? sh : data;
          valid_n = rx_s;
          ferr_n  = !rx_s;
        end
      end
      BRK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a serial-timing reference model
module tb_uart_rx;
  localparam int N = 8;
  localparam int H = N / 2;
  localparam int LAT = H + 2 + 9 * N;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, busy;
  int cyc = 0, checks = 0, errors = 0, busy_cnt = 0, excl_bad = 0;
  logic [7:0] last = 8'h00;
  typedef struct {int t; logic k; logic [7:0] d;} ev_t;
  ev_t got[$];
  ev_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  // Edge counter: after rising edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;
  // Record every strobe cycle and busy cycle mid-period
  always @(negedge clk) begin
    if (valid || frame_err) got.push_back('{cyc, frame_err, data});
    if (busy) busy_cnt++;
    if (valid && frame_err) excl_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (N) @(posedge clk);
    #1;
  endtask

  // Model: a frame whose line first goes low before edge t0 strobes after edge t0+LAT
  task automatic send_frame(input logic [7:0] b, input logic stop);
    int t0;
    t0 = cyc + 1;
    if (stop) begin
      exp_q.push_back('{t0 + LAT, 1'b0, b});
      last = b;
    end else exp_q.push_back('{t0 + LAT, 1'b1, last});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic compare(input string tag);
    repeat (2 * N) @(posedge clk);
    #1;
    chk({tag, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({tag, " time"}, got[i].t, exp_q[i].t);
      chk({tag, " kind"}, {31'd0, got[i].k}, {31'd0, exp_q[i].k});
      chk({tag, " data"}, {24'd0, got[i].d}, {24'd0, exp_q[i].d});
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] c3;
    logic [7:0] b;
    int gap;
    c3 = 8'hC3;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset data", {24'd0, data}, 32'h0);
    chk("reset valid", {31'd0, valid}, 32'h0);
    chk("reset frame_err", {31'd0, frame_err}, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    busy_cnt = 0;
    repeat (200) @(posedge clk);
    #1;
    chk("idle busy cycles", busy_cnt, 0);
    compare("idle");

    send_frame(8'hA5, 1'b1);
    compare("single A5");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    compare("back-to-back");

    busy_cnt = 0;
    rx = 1'b0;
    repeat (H - 2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * N) @(posedge clk);
    #1;
    chk("glitch busy cycles", busy_cnt, H);
    compare("glitch");

    send_frame(8'h3C, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("break busy before idle", {31'd0, busy}, 32'h1);
    @(negedge clk);
    chk("break busy idle", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1;
    compare("framing");
    chk("data kept after frame error", {24'd0, data}, 32'h55);
    send_frame(8'h81, 1'b1);
    compare("after break");

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    rx = c3[4];
    repeat (N / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid-frame reset busy", {31'd0, busy}, 32'h0);
    chk("mid-frame reset data", {24'd0, data}, 32'h0);
    rst = 1'b0;
    last = 8'h00;
    repeat (3 * N) @(posedge clk);
    #1;
    compare("reset abort");
    send_frame(8'h7E, 1'b1);
    compare("after reset");

    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 2);
      send_frame(b, 1'b1);
      for (int g = 0; g < gap; g++) send_bit(1'b1);
    end
    compare("random");

    chk("valid/frame_err exclusive", excl_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
